// File: rtl/alu_mdu.sv
// EX-stage ALU with single-cycle shift/arith/logic/compare ops and an iterative
// unsigned multiply/divide unit that writes internal HI/LO registers.
module alu_mdu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] Src_1,
  input  logic [WIDTH-1:0] Src_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult
);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_ADD   = 6'b001011;
  localparam logic [5:0] F_SUB   = 6'b001101;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_next;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc, low;
  logic [WIDTH-1:0] acc_next, low_next;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic             accept;
  logic             last_step;
  logic             is_mdu;

  function automatic logic [WIDTH-1:0] single_op(
    input logic [5:0]       f,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [SHW-1:0]   sh,
    input logic [WIDTH-1:0] hi_v,
    input logic [WIDTH-1:0] lo_v
  );
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        r;
    a_s = signed'(a);
    b_s = signed'(b);
    r   = '0;
    case (f)
      F_SLL:  r = a << sh;
      F_SRL:  r = a >> sh;
      F_SRA:  r = a_s >>> sh;
      F_ADD:  r = a + b;
      F_SUB:  r = a - b;
      F_AND:  r = a & b;
      F_OR:   r = a | b;
      F_XOR:  r = a ^ b;
      F_SLT:  r[0] = (a_s < b_s);
      F_MFHI: r = hi_v;
      F_MFLO: r = lo_v;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = start && (state == IDLE);
  assign is_mdu    = (funct == F_MULTU) || (funct == F_DIVU);
  assign last_step = (state != IDLE) && (cnt == CNT_LAST);

  // Shared iteration datapath: acc is the running high half / partial remainder,
  // low is the multiplier shifting out / dividend shifting into the quotient.
  assign mul_sum   = {1'b0, acc} + {1'b0, (low[0] ? opb : '0)};
  assign div_shift = {acc, low[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_ok    = (div_shift >= {1'b0, opb});

  always_comb begin
    acc_next = acc;
    low_next = low;
    case (state)
      MUL: begin
        acc_next = mul_sum[WIDTH:1];
        low_next = {mul_sum[0], low[WIDTH-1:1]};
      end
      DIV: begin
        acc_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        low_next = {low[WIDTH-2:0], div_ok};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept && funct == F_MULTU)     state_next = MUL;
        else if (accept && funct == F_DIVU) state_next = DIV;
      end
      MUL, DIV: begin
        if (cnt == CNT_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      ALUResult <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (accept && !is_mdu) begin
          ALUResult <= single_op(funct, Src_1, Src_2, shamt, hi, lo);
          done      <= 1'b1;
        end
      end else if (last_step) begin
        cnt       <= '0;
        hi        <= acc_next;
        lo        <= low_next;
        ALUResult <= low_next;
        done      <= 1'b1;
      end else begin
        cnt <= cnt + SHW'(1);
      end
    end
  end

  // Operand capture at accept, then one shift-add / restoring step per cycle
  always_ff @(posedge clk) begin
    if (accept && funct == F_MULTU) begin
      opb <= Src_1;
      low <= Src_2;
      acc <= '0;
    end else if (accept && funct == F_DIVU) begin
      opb <= Src_2;
      low <= Src_1;
      acc <= '0;
    end else if (state != IDLE) begin
      acc <= acc_next;
      low <= low_next;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: 32-bit and 8-bit instances, directed vectors.
module tb_alu_mdu;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_ADD   = 6'b001011;
  localparam logic [5:0] F_SUB   = 6'b001101;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a, busy_a, done_a;
  logic [5:0]  funct_a;
  logic [4:0]  shamt_a;
  logic [31:0] src1_a, src2_a, res_a;

  logic        start_b, busy_b, done_b;
  logic [5:0]  funct_b;
  logic [2:0]  shamt_b;
  logic [7:0]  src1_b, src2_b, res_b;

  alu_mdu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start_a), .funct(funct_a), .shamt(shamt_a),
    .Src_1(src1_a), .Src_2(src2_a), .busy(busy_a), .done(done_a), .ALUResult(res_a)
  );

  alu_mdu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_b), .funct(funct_b), .shamt(shamt_b),
    .Src_1(src1_b), .Src_2(src2_b), .busy(busy_b), .done(done_b), .ALUResult(res_b)
  );

  typedef struct {
    logic [31:0] val;
    int          due;
    string       name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  int busy_cnt_a = 0;
  int busy_cnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitors: every done pulse must match the oldest expected result and its cycle
  always @(negedge clk) begin
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    if (done_a) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done32: ALUResult=%h, expected no done", res_a);
      end else begin
        ea = q_a.pop_front();
        check({ea.name, "_val"}, res_a, ea.val);
        check({ea.name, "_cycle"}, 32'(cyc), 32'(ea.due));
      end
    end
  end

  always @(negedge clk) begin
    if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
    if (done_b) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: ALUResult=%h, expected no done", res_b);
      end else begin
        eb = q_b.pop_front();
        check({eb.name, "_val"}, {24'h0, res_b}, eb.val);
        check({eb.name, "_cycle"}, 32'(cyc), 32'(eb.due));
      end
    end
  end

  task automatic issue_a(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] expv, input int lat,
                         input string name);
    start_a = 1'b1; funct_a = f; src1_a = a; src2_a = b; shamt_a = sh;
    q_a.push_back('{val: expv, due: cyc + 1 + lat, name: name});
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic issue_b(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] expv, input int lat, input string name);
    start_b = 1'b1; funct_b = f; src1_b = a; src2_b = b; shamt_b = 3'd0;
    q_b.push_back('{val: {24'h0, expv}, due: cyc + 1 + lat, name: name});
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (q_a.size() > 0 || q_b.size() > 0); i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0/0",
               q_a.size(), q_b.size());
      q_a.delete();
      q_b.delete();
    end
  endtask

  initial begin
    int b0;
    int n;
    rst = 1'b1;
    start_a = 1'b0; funct_a = '0; shamt_a = '0; src1_a = '0; src2_a = '0;
    start_b = 1'b0; funct_b = '0; shamt_b = '0; src1_b = '0; src2_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy32", {31'h0, busy_a}, 32'h0);
    check("rst_done32", {31'h0, done_a}, 32'h0);
    check("rst_result32", res_a, 32'h0);
    check("rst_busy8", {31'h0, busy_b}, 32'h0);
    check("rst_result8", {24'h0, res_b}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops never raise busy
    b0 = busy_cnt_a;
    issue_a(F_ADD, 32'd5, 32'd7, 5'd0, 32'd12, 0, "add");
    issue_a(F_SUB, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 0, "sub");
    drain(5);
    check("single_busy_cycles", 32'(busy_cnt_a - b0), 32'd0);

    issue_a(F_SRL, 32'h8000_0000, 32'h0, 5'd4, 32'h0800_0000, 0, "srl");
    issue_a(F_SRA, 32'h8000_0000, 32'h0, 5'd4, 32'hF800_0000, 0, "sra");
    issue_a(F_SLL, 32'h8000_0000, 32'h0, 5'd4, 32'h0000_0000, 0, "sll");
    issue_a(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 0, "slt_neg");
    issue_a(F_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 0, "slt_pos");
    issue_a(F_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 0, "and");
    issue_a(F_OR,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 0, "or");
    issue_a(F_XOR, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_0FF0, 0, "xor");
    issue_a(6'b111111, 32'h1234, 32'h5678, 5'd0, 32'h0, 0, "illegal");
    drain(5);

    // MULTU max*max; MFHI issued in the done cycle sees the new HI
    b0 = busy_cnt_a;
    issue_a(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 32, "multu_max");
    n = 0;
    while (!done_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    issue_a(F_MFHI, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFE, 0, "mfhi_mul");
    check("multu_busy_cycles", 32'(busy_cnt_a - b0), 32'd32);
    issue_a(F_MFLO, 32'h0, 32'h0, 5'd0, 32'h0000_0001, 0, "mflo_mul");
    drain(10);

    issue_a(F_DIVU, 32'd100, 32'd7, 5'd0, 32'd14, 32, "divu");
    drain(40);
    issue_a(F_MFHI, 32'h0, 32'h0, 5'd0, 32'd2, 0, "mfhi_div");
    issue_a(F_MFLO, 32'h0, 32'h0, 5'd0, 32'd14, 0, "mflo_div");
    issue_a(F_DIVU, 32'h1234, 32'h0, 5'd0, 32'hFFFF_FFFF, 32, "divu_zero");
    drain(40);
    issue_a(F_MFHI, 32'h0, 32'h0, 5'd0, 32'h1234, 0, "mfhi_div0");
    drain(5);

    // start and operand changes while busy are ignored
    issue_a(F_MULTU, 32'd3, 32'd5, 5'd0, 32'd15, 32, "multu_ign");
    repeat (4) @(posedge clk);
    #1;
    start_a = 1'b1; funct_a = F_ADD; src1_a = 32'd100; src2_a = 32'd200;
    repeat (3) @(posedge clk);
    #1;
    start_a = 1'b0; src1_a = 32'hDEAD_BEEF; src2_a = 32'h0BAD_F00D;
    drain(40);
    issue_a(F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 0, "mfhi_ign");
    issue_a(F_MFLO, 32'h0, 32'h0, 5'd0, 32'd15, 0, "mflo_ign");
    drain(5);

    // Reset mid-MULTU discards the op
    start_a = 1'b1; funct_a = F_MULTU; src1_a = 32'd7; src2_a = 32'd9;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", {31'h0, busy_a}, 32'h0);
    check("midrst_done", {31'h0, done_a}, 32'h0);
    check("midrst_result", res_a, 32'h0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    issue_a(F_MFHI, 32'h0, 32'h0, 5'd0, 32'h0, 0, "mfhi_rst");
    issue_a(F_MFLO, 32'h0, 32'h0, 5'd0, 32'h0, 0, "mflo_rst");
    drain(5);

    // WIDTH=8 instance: 8-cycle latency
    b0 = busy_cnt_b;
    issue_b(F_MULTU, 8'd15, 8'd17, 8'hFF, 8, "multu8");
    drain(20);
    check("multu8_busy_cycles", 32'(busy_cnt_b - b0), 32'd8);
    issue_b(F_MFHI, 8'h0, 8'h0, 8'h00, 0, "mfhi8");
    issue_b(F_DIVU, 8'd200, 8'd9, 8'd22, 8, "divu8");
    drain(20);
    issue_b(F_MFHI, 8'h0, 8'h0, 8'd2, 0, "mfhi8_div");
    drain(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
